mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Port clk  input  1  single clock; all state updates on rising edge.
REQ-002 Port rst  input  1  synchronous, active-high reset.
REQ-003 Port mem_read_XM  input  1  load request from EX/MEM latch.
REQ-004 Port mem_write_XM  input  1  store request from EX/MEM latch.
REQ-005 Port alu_result_XM  input  16  effective address for loads/stores; pass-through value for non-memory ops.
REQ-006 Port write_data_XM  input  16  store data.
REQ-007 Port dmem_req  output  1  memory request, held high until accepted.
REQ-008 Port dmem_wr  output  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-009 Port dmem_addr  output  16  memory address; valid while dmem_req=1.
REQ-010 Port dmem_wdata  output  16  store data; valid while dmem_req=1.
REQ-011 Port dmem_rdata  input  16  load data; valid when dmem_ready=1.
REQ-012 Port dmem_ready  input  1  memory completion strobe.
REQ-013 Port mem_readData  output  16  result to MEM/WB latch.
REQ-014 Port stall_mem  output  1  freeze upstream stages and EX/MEM latch.
REQ-015 Port err_timeout  output  1  one-cycle pulse on access timeout.
REQ-016 Port err_align  output  1  one-cycle pulse on misaligned access (config dependent).

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; encoding free.
REQ-018 IDLE, no mem op: stall_mem=0, dmem_req=0, mem_readData=alu_result_XM combinationally; zero added latency.
REQ-019 IDLE, mem op: dmem_req=1, stall_mem=1, next state BUSY.
REQ-020 Both mem_read_XM and mem_write_XM high: treated as store; mem_readData=alu_result_XM in DONE.
REQ-021 BUSY: dmem_req=1, stall_mem=1; dmem_addr/dmem_wr/dmem_wdata stable; upstream holds inputs stable while stall_mem=1.
REQ-022 BUSY with dmem_ready=1: capture dmem_rdata into load buffer (loads only), clear wait counter, next state DONE; dmem_ready is ignored outside BUSY.
REQ-023 BUSY wait counter: 4 bits, increments each BUSY cycle with dmem_ready=0; when dmem_ready=0 and counter is 15, pulse err_timeout, load buffer=16'hDEAD, next state DONE.
REQ-024 DONE: stall_mem=0, dmem_req=0; mem_readData=load buffer for loads, alu_result_XM for stores; next state IDLE.
REQ-025 Minimum memory-op latency SHALL be 3 cycles (IDLE, BUSY, DONE); the pipeline advances at the end of DONE.
REQ-026 Back-to-back memory ops SHALL each traverse IDLE; no request in DONE.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, counter=0, load buffer=0, err_timeout=0, err_align=0, regardless of state.
REQ-028 Reset mid-BUSY SHALL drop dmem_req on that edge; an in-flight dmem_ready is ignored.
REQ-029 After reset: dmem_req=0, stall_mem=0; mem_readData follows alu_result_XM.

Configuration
REQ-030 Macro MEM_STAGE_ALIGN_CHECK_EN defined: in IDLE, a mem op with alu_result_XM[0]=1 SHALL issue no request, set stall_mem=0, pulse err_align for 1 cycle, set mem_readData=16'h0000, and remain in IDLE.
REQ-031 Macro undefined: no alignment check; err_align tied 0; the address passes unchanged.

Verification
REQ-032 Load, addr 16'h0010, dmem_ready in first BUSY cycle, rdata 16'h1234 -> stall 2 cycles, mem_readData=16'h1234 in DONE.
REQ-033 Store, addr 16'h0020, wdata 16'hBEEF, ready after 3 BUSY cycles -> dmem_wr=1 with stable addr/data for 3 cycles, stall 4 cycles.
REQ-034 Load, dmem_ready never asserted -> err_timeout pulses after 16 BUSY cycles, mem_readData=16'hDEAD in DONE.
REQ-035 Non-mem op, alu_result_XM=16'h00AA -> stall_mem=0, mem_readData=16'h00AA the same cycle.
REQ-036 rst asserted during the 2nd BUSY cycle -> dmem_req=0 and IDLE on the next edge; a later dmem_ready has no effect.
REQ-037 With MEM_STAGE_ALIGN_CHECK_EN, load addr 16'h0011 -> err_align 1 cycle, dmem_req stays 0, mem_readData=16'h0000.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: drives a request/ready data-memory handshake for loads and stores,
// stalling upstream while busy. Optional alignment check: define MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_XM,
   input  logic        mem_write_XM,
   input  logic [15:0] alu_result_XM,
   input  logic [15:0] write_data_XM,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [15:0] mem_readData,
   output logic        stall_mem,
   output logic        err_timeout,
   output logic        err_align
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_wait_cnt;
   logic [15:0] r_load_buf;
   logic        r_err_timeout;
   logic        w_mem_op;
   logic        w_is_load;
   logic        w_misaligned;
   logic        w_timeout;

   // A simultaneous read+write request is treated as a store.
   assign w_mem_op  = mem_read_XM | mem_write_XM;
   assign w_is_load = mem_read_XM & ~mem_write_XM;

   // Upstream holds its inputs stable while stalled, so the request fields pass straight through.
   assign dmem_wr    = mem_write_XM;
   assign dmem_addr  = alu_result_XM;
   assign dmem_wdata = write_data_XM;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   logic r_err_align;

   assign w_misaligned = w_mem_op & alu_result_XM[0];
   assign err_align    = r_err_align;

   always_ff @(posedge clk) begin
      if (rst)
         r_err_align <= 1'b0;
      else
         r_err_align <= (r_state == S_IDLE) && w_misaligned;
   end
`else
   assign w_misaligned = 1'b0;
   assign err_align    = 1'b0;
`endif

   assign err_timeout = r_err_timeout;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next       = r_state;
      dmem_req     = 1'b0;
      stall_mem    = 1'b0;
      mem_readData = alu_result_XM;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_misaligned) begin
               mem_readData = 16'h0000;
            end else if (w_mem_op) begin
               dmem_req  = 1'b1;
               stall_mem = 1'b1;
               w_next    = S_BUSY;
            end
         end
         S_BUSY: begin
            dmem_req  = 1'b1;
            stall_mem = 1'b1;
            if (dmem_ready) begin
               w_next = S_DONE;
            end else if (r_wait_cnt == 4'd15) begin
               w_timeout = 1'b1;
               w_next    = S_DONE;
            end
         end
         S_DONE: begin
            if (w_is_load)
               mem_readData = r_load_buf;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= 4'd0;
         r_load_buf    <= 16'h0000;
         r_err_timeout <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_err_timeout <= w_timeout;
         if (r_state == S_BUSY) begin
            if (dmem_ready) begin
               r_wait_cnt <= 4'd0;
               if (w_is_load)
                  r_load_buf <= dmem_rdata;
            end else if (w_timeout) begin
               r_wait_cnt <= 4'd0;
               r_load_buf <= 16'hDEAD;
            end else begin
               r_wait_cnt <= r_wait_cnt + 4'd1;
            end
         end
      end
   end

endmodule
